// File: rtl/input_conditioner_pkg.sv
// Shared types and timing defaults for the button/switch input conditioner.
package input_conditioner_pkg;

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } db_state_e;

  localparam int CLK_HZ = 50000000;
  localparam int DB_MS  = 20;

  // Stable-sample count for a debounce window of db_ms milliseconds.
  function automatic int db_cycles(input int clk_hz, input int db_ms);
    return (clk_hz / 1000) * db_ms;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input: 2-flop synchroniser followed by a counting debounce FSM.
// change_o is a one-cycle strobe coincident with the new level_o.
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int   DB_CYCLES = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic change_o
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            change_q, change_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    change_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != stable_q) begin
          state_d = ST_CHANGING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHANGING: begin
        // A bounce back to the held level abandons the candidate change.
        if (sync2_q == stable_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = sync2_q;
          change_d = 1'b1;
          state_d  = ST_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= RESET_VAL;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      change_q <= change_d;
    end
  end

  assign level_o  = stable_q;
  assign change_o = change_q;

endmodule

// File: rtl/input_conditioner.sv
// Board front end: debounced button/switch levels, press pulses, sticky
// press flags with per-bit clear, and a switch-change strobe.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_BTN          = 2,
  parameter int N_SW           = 4,
  parameter int DB_CYCLES      = db_cycles(CLK_HZ, DB_MS),
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_export,
  output logic [N_SW-1:0]  switches_export,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_event,
  input  logic [N_BTN-1:0] event_clr,
  output logic             sw_change
);

  localparam logic BTN_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [N_BTN-1:0] btn_lvl, btn_chg;
  logic [N_SW-1:0]  sw_lvl, sw_chg;
  logic [N_BTN-1:0] btn_event_q, btn_event_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES),
      .RESET_VAL(BTN_IDLE)
    ) u_cell (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (btn_raw[i]),
      .level_o (btn_lvl[i]),
      .change_o(btn_chg[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES),
      .RESET_VAL(1'b0)
    ) u_cell (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (sw_raw[i]),
      .level_o (sw_lvl[i]),
      .change_o(sw_chg[i])
    );
  end

  // Both terms are flops, so the pulse lines up with the new pressed level.
  assign btn_press = btn_chg & (btn_lvl ^ {N_BTN{BTN_IDLE}});

  // A press in the same cycle as a clear keeps the flag set.
  assign btn_event_d = btn_press | (btn_event_q & ~event_clr);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      btn_event_q <= '0;
    end else begin
      btn_event_q <= btn_event_d;
    end
  end

  assign btn_export      = btn_lvl;
  assign switches_export = sw_lvl;
  assign btn_event       = btn_event_q;
  assign sw_change       = |sw_chg;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DB_CYCLES=8: directed table, corner
// sequences and randomized stimulus against a window-based reference model.
module tb_input_conditioner;

  localparam int NB = 2;
  localparam int NS = 4;
  localparam int NI = NB + NS;
  localparam int D  = 8;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NS-1:0] sw_raw = '0;
  logic [NB-1:0] event_clr = '0;
  logic [NB-1:0] btn_export, btn_press, btn_event;
  logic [NS-1:0] switches_export;
  logic          sw_change;

  input_conditioner #(
    .N_BTN(NB),
    .N_SW(NS),
    .DB_CYCLES(D),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .btn_raw        (btn_raw),
    .sw_raw         (sw_raw),
    .btn_export     (btn_export),
    .switches_export(switches_export),
    .btn_press      (btn_press),
    .btn_event      (btn_event),
    .event_clr      (event_clr),
    .sw_change      (sw_change)
  );

  // Packed view: {btn_export, switches_export, btn_press, btn_event, sw_change}
  logic [10:0] dut_vec;
  assign dut_vec = {btn_export, switches_export, btn_press, btn_event, sw_change};

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  // Reference model: an input's level flips once D consecutive synchronised
  // samples (taken after the last flip or reset) all differ from it.
  bit   m_s1[NI], m_s2[NI], m_out[NI], m_chg[NI];
  bit   m_win[NI][$];
  logic [NB-1:0] m_press = '0;
  logic [NB-1:0] m_event = '0;
  logic          m_swchg = 1'b0;

  function automatic bit idle_of(input int i);
    return (i < NB);
  endfunction

  function automatic bit raw_bit(input int i);
    return (i < NB) ? btn_raw[i] : sw_raw[i-NB];
  endfunction

  function automatic logic [10:0] m_pack();
    return {m_out[1], m_out[0], m_out[5], m_out[4], m_out[3], m_out[2],
            m_press, m_event, m_swchg};
  endfunction

  task automatic model_step();
    logic [NB-1:0] press_prev;
    bit seen, all_diff;
    press_prev = m_press;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_s1[i]  = idle_of(i);
        m_s2[i]  = idle_of(i);
        m_out[i] = idle_of(i);
        m_chg[i] = 1'b0;
        m_win[i].delete();
      end
      m_press = '0;
      m_event = '0;
      m_swchg = 1'b0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        seen     = m_s2[i];
        m_s2[i]  = m_s1[i];
        m_s1[i]  = raw_bit(i);
        m_chg[i] = 1'b0;
        m_win[i].push_back(seen);
        if (m_win[i].size() > D) void'(m_win[i].pop_front());
        if (m_win[i].size() == D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (m_win[i][j] == m_out[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_out[i] = !m_out[i];
            m_chg[i] = 1'b1;
            m_win[i].delete();
          end
        end
      end
      m_event = press_prev | (m_event & ~event_clr);
      for (int b = 0; b < NB; b++) m_press[b] = m_chg[b] && (m_out[b] == 1'b0);
      m_swchg = m_chg[2] | m_chg[3] | m_chg[4] | m_chg[5];
    end
  endtask

  // Driver: one clock edge; model advances on the edge, DUT compared at negedge.
  task automatic cycle(input bit chk_tab, input logic [10:0] tab_exp, input string name);
    logic [10:0] e;
    @(posedge clk);
    model_step();
    exp_q.push_back(m_pack());
    @(negedge clk);
    e = exp_q.pop_front();
    check("model", {21'd0, dut_vec}, {21'd0, e});
    if (chk_tab) check(name, {21'd0, dut_vec}, {21'd0, tab_exp});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, "");
  endtask

  typedef struct {
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NS-1:0] sw;
    logic [NB-1:0] clr;
    int            n;
    logic [10:0]   exp;
  } vec_t;

  vec_t tab[$];
  int   cnt_a;
  logic seen_a;

  initial begin
    // Reset, power-up acceptance, clean press/release, event clear.
    tab.push_back('{1'b0, 2'b00, 4'b1111, 2'b00, 3, 11'b11_0000_00_00_0});
    tab.push_back('{1'b1, 2'b00, 4'b1111, 2'b00, 9, 11'b11_0000_00_00_0});
    tab.push_back('{1'b1, 2'b00, 4'b1111, 2'b00, 1, 11'b00_1111_11_00_1});
    tab.push_back('{1'b1, 2'b00, 4'b1111, 2'b00, 1, 11'b00_1111_00_11_0});
    tab.push_back('{1'b1, 2'b11, 4'b1111, 2'b00, 9, 11'b00_1111_00_11_0});
    tab.push_back('{1'b1, 2'b11, 4'b1111, 2'b00, 1, 11'b11_1111_00_11_0});
    tab.push_back('{1'b1, 2'b11, 4'b1111, 2'b11, 1, 11'b11_1111_00_00_0});
    tab.push_back('{1'b1, 2'b10, 4'b1111, 2'b00, 9, 11'b11_1111_00_00_0});
    tab.push_back('{1'b1, 2'b10, 4'b1111, 2'b00, 1, 11'b10_1111_01_00_0});
    tab.push_back('{1'b1, 2'b10, 4'b1111, 2'b00, 3, 11'b10_1111_00_01_0});
    tab.push_back('{1'b1, 2'b11, 4'b1111, 2'b00, 9, 11'b10_1111_00_01_0});
    tab.push_back('{1'b1, 2'b11, 4'b1111, 2'b00, 2, 11'b11_1111_00_01_0});

    rst_n = tab[0].rst_n; btn_raw = tab[0].btn; sw_raw = tab[0].sw; event_clr = tab[0].clr;
    foreach (tab[r]) begin
      rst_n = tab[r].rst_n; btn_raw = tab[r].btn; sw_raw = tab[r].sw; event_clr = tab[r].clr;
      for (int k = 0; k < tab[r].n; k++) cycle(1'b1, tab[r].exp, $sformatf("table_row%0d", r));
    end

    // Bounce on button 1: 3 low / 2 high, four times.
    seen_a = 1'b0;
    for (int rep = 0; rep < 4; rep++) begin
      btn_raw = 2'b01;
      for (int k = 0; k < 3; k++) begin cycle(1'b0, '0, ""); seen_a |= |btn_press; end
      btn_raw = 2'b11;
      for (int k = 0; k < 2; k++) begin cycle(1'b0, '0, ""); seen_a |= |btn_press; end
    end
    for (int k = 0; k < 12; k++) begin cycle(1'b0, '0, ""); seen_a |= |btn_press; end
    check("bounce_level", {30'd0, btn_export}, 32'b11);
    check("bounce_no_press", {31'd0, seen_a}, 32'd0);
    check("bounce_event_kept", {30'd0, btn_event}, 32'b01);

    // Clear coincident with a new press, then clear alone.
    btn_raw = 2'b10;
    idle_cycles(10);
    check("press_again", {30'd0, btn_press}, 32'b01);
    event_clr = 2'b01;
    cycle(1'b0, '0, "");
    check("clr_with_press", {31'd0, btn_event[0]}, 32'd1);
    cycle(1'b0, '0, "");
    check("clr_alone", {31'd0, btn_event[0]}, 32'd0);
    event_clr = 2'b00;
    btn_raw = 2'b11;
    idle_cycles(12);

    // Reset mid-debounce with the counter at 5.
    btn_raw = 2'b10;
    idle_cycles(7);
    rst_n = 1'b0;
    cycle(1'b0, '0, "");
    check("mid_rst_btn", {30'd0, btn_export}, 32'b11);
    check("mid_rst_sw", {28'd0, switches_export}, 32'd0);
    rst_n = 1'b1;
    seen_a = 1'b0;
    for (int k = 0; k < 9; k++) begin cycle(1'b0, '0, ""); seen_a |= !btn_export[0]; end
    check("post_rst_wait", {31'd0, seen_a}, 32'd0);
    cycle(1'b0, '0, "");
    check("post_rst_level", {31'd0, btn_export[0]}, 32'd0);
    check("post_rst_press", {30'd0, btn_press}, 32'b01);
    cycle(1'b0, '0, "");
    check("post_rst_single", {30'd0, btn_press}, 32'b00);

    // Switches 0000 -> 1010 with bit 3 bouncing for 2 cycles.
    sw_raw = 4'b0000;
    idle_cycles(12);
    cnt_a = 0;
    for (int j = 0; j < 20; j++) begin
      sw_raw = (j == 2 || j == 3) ? 4'b0010 : 4'b1010;
      cycle(1'b0, '0, "");
      if (sw_change) cnt_a++;
      if (j == 8)  check("sw_clean_before", {28'd0, switches_export}, 32'b0000);
      if (j == 9)  check("sw_clean_bit", {28'd0, switches_export}, 32'b0010);
      if (j == 12) check("sw_bounce_before", {28'd0, switches_export}, 32'b0010);
      if (j == 13) check("sw_bounce_bit", {28'd0, switches_export}, 32'b1010);
    end
    check("sw_pulses", cnt_a, 32'd2);
    check("sw_final", {28'd0, switches_export}, 32'b1010);

    // Randomized stimulus against the model.
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
      for (int s = 0; s < NS; s++) if ($urandom_range(0, 9) == 0) sw_raw[s] = ~sw_raw[s];
      event_clr = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 3)) : '0;
      cycle(1'b0, '0, "");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
